iod_frame_ctrl: RTL and testbench

//  Single-clock sequencer for the 24-bit serial I/O shifter (Morse TX/RX path).
//  - Takes one word per start request and drives the shifter's word-load, bit-shift and capture strobes at a programmable bit rate.
//  - Returns the word shifted in over the same frame.
//  - Sits between the Morse encoder/decoder control logic and the shifter; the shifter's clock inputs are fed from these strobes.

---
 rtl/iod_frame_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_iod_frame_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iod_frame_ctrl.sv
// -----------------------------------------------------------------------------
// iod_frame_ctrl
// Frame sequencer for the 24-bit serial I/O shifter used by the Morse TX/RX
// path. One accepted start produces one frame of strobes:
//   load -> WORD_W shifts (one per bit period) -> capture -> done.
// The shifter clock inputs are fed from these strobes.
//
// Every output is a register. The value it takes at a clock edge is decoded
// from the state held before that edge. As a result, the strobes appear one
// cycle after the state that produces them is entered.
//
// Optional feature macro: IODC_OVERRUN_EN
//   When defined, the block adds a sticky 'overrun' output. The flag is set
//   when a start request arrives while a frame is in progress. It is cleared
//   by the next accepted start.
// -----------------------------------------------------------------------------
module iod_frame_ctrl #(
  parameter int unsigned WORD_W = 24,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] tx_data,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [WORD_W-1:0] iod_dr,
  output logic [WORD_W-1:0] iod_dw,
  output logic              iod_load,
  output logic              iod_shift,
  output logic              iod_capt,
  output logic              iod_enw,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid
`ifdef IODC_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  // The bit counter must be able to hold WORD_W itself, so it has one extra value.
  localparam int unsigned BC_W = $clog2(WORD_W + 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [DIV_W-1:0]  div_r, div_s;
  logic [DIV_W-1:0]  cnt_r, cnt_s;
  logic [BC_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic [WORD_W-1:0] iod_dw_r, iod_dw_s;
  logic [WORD_W-1:0] rx_data_r, rx_data_s;
  logic              iod_load_r, iod_load_s;
  logic              iod_shift_r, iod_shift_s;
  logic              iod_capt_r, iod_capt_s;
  logic              iod_enw_r, iod_enw_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              rx_valid_r;
  logic              accept_s;
  logic              frame_act_s;

  // A frame is active whenever the FSM is outside IDLE.
  // A start is taken only in IDLE, and an abort in the same cycle blocks it.
  assign frame_act_s = (state_r != ST_IDLE);
  assign accept_s    = (state_r == ST_IDLE) && start && !abort;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    cnt_s       = cnt_r;
    bit_cnt_s   = bit_cnt_r;
    iod_dw_s    = iod_dw_r;
    rx_data_s   = rx_data_r;
    iod_load_s  = 1'b0;
    iod_shift_s = 1'b0;
    iod_capt_s  = 1'b0;
    iod_enw_s   = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;

    if (abort && frame_act_s) begin
      // Cancel: back to IDLE with every strobe low and rx_data untouched.
      state_s   = ST_IDLE;
      cnt_s     = DIV_ZERO;
      bit_cnt_s = {BC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            iod_dw_s = tx_data;
            div_s    = (baud_div == DIV_ZERO) ? DIV_ONE : baud_div;
            state_s  = ST_LOAD;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          iod_load_s = 1'b1;
          iod_enw_s  = 1'b1;
          busy_s     = 1'b1;
          bit_cnt_s  = {BC_W{1'b0}};
          cnt_s      = div_r;
          state_s    = ST_SHIFT;
        end
        ST_SHIFT: begin
          iod_enw_s = 1'b1;
          busy_s    = 1'b1;
          // cnt_r never holds 0 here. Using <= keeps a corrupted count from stalling the frame.
          if (cnt_r <= DIV_ONE) begin
            iod_shift_s = 1'b1;
            cnt_s       = div_r;
            bit_cnt_s   = bit_cnt_r + BC_ONE;
            if (bit_cnt_r >= LAST_BIT) begin
              state_s = ST_CAPT;
            end else begin
              state_s = ST_SHIFT;
            end
          end else begin
            cnt_s = cnt_r - DIV_ONE;
          end
        end
        ST_CAPT: begin
          iod_capt_s = 1'b1;
          iod_enw_s  = 1'b1;
          busy_s     = 1'b1;
          state_s    = ST_DONE;
        end
        ST_DONE: begin
          iod_enw_s = 1'b1;
          busy_s    = 1'b1;
          done_s    = 1'b1;
          rx_data_s = iod_dr;
          state_s   = ST_IDLE;
        end
        default: begin
          state_s   = ST_IDLE;
          cnt_s     = DIV_ZERO;
          bit_cnt_s = {BC_W{1'b0}};
        end
      endcase
    end
  end

  // State, counters and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      div_r       <= DIV_ZERO;
      cnt_r       <= DIV_ZERO;
      bit_cnt_r   <= {BC_W{1'b0}};
      iod_dw_r    <= {WORD_W{1'b0}};
      rx_data_r   <= {WORD_W{1'b0}};
      iod_load_r  <= 1'b0;
      iod_shift_r <= 1'b0;
      iod_capt_r  <= 1'b0;
      iod_enw_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rx_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      cnt_r       <= cnt_s;
      bit_cnt_r   <= bit_cnt_s;
      iod_dw_r    <= iod_dw_s;
      rx_data_r   <= rx_data_s;
      iod_load_r  <= iod_load_s;
      iod_shift_r <= iod_shift_s;
      iod_capt_r  <= iod_capt_s;
      iod_enw_r   <= iod_enw_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      rx_valid_r  <= done_s;
    end
  end

`ifdef IODC_OVERRUN_EN
  logic overrun_r, overrun_s;

  // Sticky overrun: an accepted start clears the flag, but a same-cycle overrun wins.
  always_comb begin
    overrun_s = overrun_r;
    if (start && frame_act_s) begin
      overrun_s = 1'b1;
    end else if (accept_s) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_s;
    end
  end

  assign overrun = overrun_r;
`endif

  assign iod_dw    = iod_dw_r;
  assign iod_load  = iod_load_r;
  assign iod_shift = iod_shift_r;
  assign iod_capt  = iod_capt_r;
  assign iod_enw   = iod_enw_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;

endmodule

// File: tb/tb_iod_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iod_frame_ctrl
// Self-checking bench for iod_frame_ctrl.
// The reference model works from a frame schedule. It records the accept edge
// t0 and the bit period d of each frame. Expected strobes then follow from
// arithmetic on (edge - t0):
//   load at +1, shifts at +1+k*d (k = 1..24), capt at +2+24d, done at +3+24d.
// Directed frames are pinned with hand-computed cycle numbers. A randomized
// phase follows them.
// -----------------------------------------------------------------------------
module tb_iod_frame_ctrl;
  localparam int W = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] tx_data = 24'h0;
  logic [15:0] baud_div = 16'h1;
  logic [23:0] iod_dr = 24'h0;
  logic [23:0] iod_dw;
  logic        iod_load, iod_shift, iod_capt, iod_enw, busy, done, rx_valid;
  logic [23:0] rx_data;
`ifdef IODC_OVERRUN_EN
  logic        overrun;
`endif

  iod_frame_ctrl #(.WORD_W(24), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .tx_data(tx_data), .baud_div(baud_div), .iod_dr(iod_dr),
    .iod_dw(iod_dw), .iod_load(iod_load), .iod_shift(iod_shift),
    .iod_capt(iod_capt), .iod_enw(iod_enw), .busy(busy), .done(done),
    .rx_data(rx_data), .rx_valid(rx_valid)
`ifdef IODC_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int base = 0;

  // model state
  bit          m_active;
  int          m_t0, m_div;
  logic [23:0] m_dw, m_rx;
  bit          e_load, e_shift, e_capt, e_enw, e_busy, e_done;

  // observation recorders for literal pins
  int n_shift, first_shift, last_shift, load_at, capt_at;
  int done_at[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_dw = 24'h0;
    m_rx = 24'h0;
    e_load = 1'b0; e_shift = 1'b0; e_capt = 1'b0;
    e_enw = 1'b0; e_busy = 1'b0; e_done = 1'b0;
  endtask

  task automatic model_edge();
    int rel, d;
    e_load = 1'b0; e_shift = 1'b0; e_capt = 1'b0;
    e_enw = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (!rst) begin
      model_reset();
    end else if (m_active && abort) begin
      m_active = 1'b0;
    end else if (m_active) begin
      d = m_div;
      rel = cyc - m_t0;
      e_enw = 1'b1;
      e_busy = 1'b1;
      e_load = (rel == 1);
      e_shift = (rel >= 1 + d) && (rel <= 1 + W * d) && ((rel - 1) % d == 0);
      e_capt = (rel == 2 + W * d);
      if (rel == 3 + W * d) begin
        e_done = 1'b1;
        m_rx = iod_dr;
        m_active = 1'b0;
      end
    end else if (start && !abort) begin
      m_active = 1'b1;
      m_t0 = cyc;
      m_div = (baud_div == 16'h0) ? 1 : int'(baud_div);
      m_dw = tx_data;
    end
  endtask

  task automatic compare_all();
    chk("iod_dw",    32'(iod_dw),    32'(m_dw));
    chk("iod_load",  32'(iod_load),  32'(e_load));
    chk("iod_shift", 32'(iod_shift), 32'(e_shift));
    chk("iod_capt",  32'(iod_capt),  32'(e_capt));
    chk("iod_enw",   32'(iod_enw),   32'(e_enw));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("done",      32'(done),      32'(e_done));
    chk("rx_valid",  32'(rx_valid),  32'(e_done));
    chk("rx_data",   32'(rx_data),   32'(m_rx));
  endtask

  task automatic clear_rec();
    n_shift = 0; first_shift = -1; last_shift = -1; load_at = -1; capt_at = -1;
    done_at.delete();
  endtask

  task automatic record();
    if (iod_load) load_at = cyc;
    if (iod_shift) begin
      if (n_shift == 0) first_shift = cyc;
      last_shift = cyc;
      n_shift++;
    end
    if (iod_capt) capt_at = cyc;
    if (done) done_at.push_back(cyc);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
    record();
  endtask

  function automatic int first_done();
    if (done_at.size() == 0) return -1;
    return done_at[0];
  endfunction

  task automatic run_until_done(input int budget);
    int n = 0;
    while (done_at.size() == 0 && n < budget) begin
      step();
      n++;
    end
    chk("done_within_budget", 32'(done_at.size() > 0), 32'd1);
  endtask

  task automatic run_until_rel(input int rel);
    while (cyc - base < rel) step();
  endtask

  task automatic launch(input logic [15:0] div, input logic [23:0] word, input logic [23:0] dr);
    baud_div = div; tx_data = word; iod_dr = dr;
    clear_rec();
    start = 1'b1;
    step();
    base = cyc;
    start = 1'b0;
  endtask

  task automatic async_reset(input int hold);
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < hold; i++) step();
    rst = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    // reset state
    #2;
    async_reset(2);
    chk("reset_iod_dw", 32'(iod_dw), 32'h0);

    // T1: div=1, loopback word
    launch(16'd1, 24'hA5C3F0, 24'hA5C3F0);
    run_until_done(200);
    chk("t1_load_at",  32'(load_at - base), 32'd1);
    chk("t1_first_sh", 32'(first_shift - base), 32'd2);
    chk("t1_last_sh",  32'(last_shift - base), 32'd25);
    chk("t1_n_shift",  32'(n_shift), 32'd24);
    chk("t1_capt_at",  32'(capt_at - base), 32'd26);
    chk("t1_done_at",  32'(first_done() - base), 32'd27);
    chk("t1_rx_data",  32'(rx_data), 32'hA5C3F0);
    chk("t1_iod_dw",   32'(iod_dw), 32'hA5C3F0);
    step();

    // T2: div=4, inputs changed mid-frame have no effect
    launch(16'd4, 24'h123456, 24'h0F0F0F);
    baud_div = 16'd7; tx_data = 24'hFFFFFF;
    run_until_done(300);
    chk("t2_n_shift",  32'(n_shift), 32'd24);
    chk("t2_first_sh", 32'(first_shift - base), 32'd5);
    chk("t2_span",     32'(last_shift - first_shift), 32'd92);
    chk("t2_done_at",  32'(first_done() - base), 32'd99);
    chk("t2_rx_data",  32'(rx_data), 32'h0F0F0F);
    chk("t2_iod_dw",   32'(iod_dw), 32'h123456);
    step();

    // T3: div=0 behaves as div=1
    launch(16'd0, 24'h5A5A5A, 24'h3C3C3C);
    run_until_done(200);
    chk("t3_first_sh", 32'(first_shift - base), 32'd2);
    chk("t3_done_at",  32'(first_done() - base), 32'd27);
    step();

    // T4: abort after the 10th shift
    launch(16'd1, 24'h00BEEF, 24'h777777);
    n = 0;
    while (n_shift < 10 && n < 100) begin step(); n++; end
    chk("t4_ten_shifts", 32'(n_shift), 32'd10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_enw_off",  32'(iod_enw), 32'd0);
    chk("t4_busy_off", 32'(busy), 32'd0);
    for (int i = 0; i < 40; i++) step();
    chk("t4_no_done",  32'(done_at.size()), 32'd0);
    chk("t4_rx_kept",  32'(rx_data), 32'h3C3C3C);
    launch(16'd1, 24'h00BEEF, 24'h777777);
    run_until_done(200);
    chk("t4_redo_done", 32'(first_done() - base), 32'd27);
    chk("t4_redo_rx",   32'(rx_data), 32'h777777);
    step();

    // T5: start pulse mid-frame is ignored
    launch(16'd2, 24'hC0FFEE, 24'h135790);
    run_until_rel(39);
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_rel(70);
    chk("t5_one_done", 32'(done_at.size()), 32'd1);
    chk("t5_done_at",  32'(first_done() - base), 32'd51);

    // T6: start held high -> back-to-back frames
    baud_div = 16'd1; tx_data = 24'h111111; iod_dr = 24'h222222;
    clear_rec();
    start = 1'b1;
    step();
    base = cyc;
    run_until_rel(83);
    start = 1'b0;
    run_until_rel(90);
    chk("t6_n_done", 32'(done_at.size()), 32'd3);
    if (done_at.size() == 3) begin
      chk("t6_done0", 32'(done_at[0] - base), 32'd27);
      chk("t6_done1", 32'(done_at[1] - base), 32'd55);
      chk("t6_done2", 32'(done_at[2] - base), 32'd83);
    end

    // T6b: async reset mid-frame at cycle 60
    clear_rec();
    start = 1'b1;
    step();
    base = cyc;
    run_until_rel(60);
    rst = 1'b0;
    #1;
    model_reset();
    chk("t6b_busy0",  32'(busy), 32'd0);
    chk("t6b_enw0",   32'(iod_enw), 32'd0);
    chk("t6b_shift0", 32'(iod_shift), 32'd0);
    chk("t6b_dw0",    32'(iod_dw), 32'd0);
    chk("t6b_rx0",    32'(rx_data), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("t6b_n_done", 32'(done_at.size()), 32'd2);
    start = 1'b0;
    rst = 1'b1;
    step();

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 9) < 3);
      abort    = ($urandom_range(0, 99) < 2);
      baud_div = 16'($urandom_range(0, 4));
      tx_data  = 24'($urandom);
      iod_dr   = 24'($urandom);
      if (i == 1500) begin
        start = 1'b0;
        abort = 1'b0;
        async_reset(2);
      end
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 5; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
